whack_ctrl: RTL



---
 rtl/whack_pkg.sv | 16 +
 rtl/bcd_counter.sv | 56 +++++
 rtl/whack_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package whack_pkg;

    typedef enum logic [1:0] {StIdle, StGap, StUp, StOver} state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with synchronous clear and an increment that saturates at all 9s.
module bcd_counter
    import whack_pkg::*;
#(
    parameter int unsigned SCORE_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      inc_i,
    output logic [4*SCORE_DIGITS-1:0] value_o
);

    bcd_digit_t [SCORE_DIGITS-1:0] digits_q, digits_d;
    logic all_nines;
    logic carry;

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (digits_q[i] != 4'd9) all_nines = 1'b0;
        end
    end

    // Ripple carry through the digits; a saturated counter stays put.
    always_comb begin
        digits_d = digits_q;
        carry    = 1'b0;
        if (clr_i) begin
            digits_d = '0;
        end else if (inc_i && !all_nines) begin
            carry = 1'b1;
            for (int i = 0; i < SCORE_DIGITS; i++) begin
                if (carry) begin
                    if (digits_q[i] == 4'd9) begin
                        digits_d[i] = 4'd0;
                    end else begin
                        digits_d[i] = digits_q[i] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q <= '0;
        end else begin
            digits_q <= digits_d;
        end
    end

    assign value_o = digits_q;

endmodule

// File: rtl/whack_ctrl.sv
// Whack-a-mole game controller: pops pseudo-random moles, judges presses, keeps score and misses.
module whack_ctrl
    import whack_pkg::*;
#(
    parameter int unsigned N_HOLES      = 4,
    parameter int unsigned MOLE_TICKS   = 50_000_000,
    parameter int unsigned GAP_TICKS    = 25_000_000,
    parameter int unsigned MAX_MISSES   = 3,
    parameter int unsigned SCORE_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_HOLES-1:0]        hit,
    output logic [N_HOLES-1:0]        mole,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [3:0]                misses,
    output logic                      hit_ok,
    output logic                      miss,
    output logic                      playing,
    output logic                      game_over
);

    localparam int unsigned MaxTicks = (GAP_TICKS > MOLE_TICKS) ? GAP_TICKS : MOLE_TICKS;
    localparam int unsigned TW       = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
    localparam int unsigned HW       = $clog2(N_HOLES);
    localparam logic [TW-1:0] GapLoad   = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] MoleLoad  = TW'(MOLE_TICKS - 1);
    localparam logic [3:0]    MissLimit = 4'(MAX_MISSES);

    state_e               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [N_HOLES-1:0]   mole_q, mole_d;
    logic [3:0]           misses_q, misses_d;
    logic                 hit_ok_q, hit_ok_d;
    logic                 miss_q, miss_d;
    logic                 playing_q, playing_d;
    logic                 over_q, over_d;
    logic [HW-1:0]        prev_q, prev_d;
    logic                 prev_vld_q, prev_vld_d;
    logic [HW-1:0]        sel;
    logic                 miss_evt;
    logic                 score_clr;
    logic                 score_inc;

    // Never show the same hole twice in a row; bumping by one wraps since N_HOLES is a power of two.
    always_comb begin
        sel = lfsr_q[HW-1:0];
        if (prev_vld_q && (sel == prev_q)) sel = sel + HW'(1);
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_step(lfsr_q);
        timer_d    = timer_q;
        mole_d     = mole_q;
        misses_d   = misses_q;
        hit_ok_d   = 1'b0;
        miss_d     = 1'b0;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        miss_evt   = 1'b0;
        score_clr  = 1'b0;
        score_inc  = 1'b0;

        case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    score_clr = 1'b1;
                    misses_d  = '0;
                    mole_d    = '0;
                    timer_d   = GapLoad;
                    state_d   = StGap;
                end
            end
            StGap: begin
                mole_d = '0;
                if (timer_q == '0) begin
                    mole_d      = '0;
                    mole_d[sel] = 1'b1;
                    prev_d      = sel;
                    prev_vld_d  = 1'b1;
                    timer_d     = MoleLoad;
                    state_d     = StUp;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StUp: begin
                if (|(hit & mole_q)) begin
                    score_inc = 1'b1;
                    hit_ok_d  = 1'b1;
                    mole_d    = '0;
                    timer_d   = GapLoad;
                    state_d   = StGap;
                end else begin
                    if (timer_q == '0) begin
                        miss_evt = 1'b1;
                        mole_d   = '0;
                        timer_d  = GapLoad;
                        state_d  = StGap;
                    end else begin
                        timer_d = timer_q - TW'(1);
                        if (|hit) miss_evt = 1'b1;
                    end
                    // A wrong press and a timeout in the same cycle cost a single miss.
                    if (miss_evt) begin
                        miss_d   = 1'b1;
                        misses_d = misses_q + 4'd1;
                        if (misses_d == MissLimit) begin
                            mole_d  = '0;
                            state_d = StOver;
                        end
                    end
                end
            end
            default: begin
                mole_d  = '0;
                state_d = StIdle;
            end
        endcase

        playing_d = (state_d == StGap) || (state_d == StUp);
        over_d    = (state_d == StOver);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lfsr_q     <= LFSR_SEED;
            timer_q    <= '0;
            mole_q     <= '0;
            misses_q   <= '0;
            hit_ok_q   <= 1'b0;
            miss_q     <= 1'b0;
            playing_q  <= 1'b0;
            over_q     <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            timer_q    <= timer_d;
            mole_q     <= mole_d;
            misses_q   <= misses_d;
            hit_ok_q   <= hit_ok_d;
            miss_q     <= miss_d;
            playing_q  <= playing_d;
            over_q     <= over_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    bcd_counter #(
        .SCORE_DIGITS(SCORE_DIGITS)
    ) u_score (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (score_clr),
        .inc_i  (score_inc),
        .value_o(score_bcd)
    );

    assign mole      = mole_q;
    assign misses    = misses_q;
    assign hit_ok    = hit_ok_q;
    assign miss      = miss_q;
    assign playing   = playing_q;
    assign game_over = over_q;

endmodule
